fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one `fifo` write port (`i_Data_Valid`/`i_Data`/`o_Full`) between up to NUM_REQ command sources in the TM1638 design, e.g. display refresh, key-scan poll and host command paths. Each source submits packets of one or more words. A packet is written to the FIFO contiguously, and arbitration happens only at packet boundaries. The block sits directly in front of the FIFO and drives its write side combinationally from the granted source.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo.sv | 63 ++++++
 rtl/rr_priority_pick.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and limits for the FIFO write-port arbiter.
package fifo_arb_pkg;

   localparam int unsigned MAX_NUM_REQ = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO; o_Full/o_Empty decode a registered count.
module fifo #(
   parameter int unsigned DATA_WIDTH = 17,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_Data_Valid,
   input  logic [DATA_WIDTH-1:0] i_Data,
   output logic                  o_Full,
   input  logic                  i_Read,
   output logic [DATA_WIDTH-1:0] o_Data,
   output logic                  o_Empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] r_Mem [DEPTH];
   logic [AW-1:0]         r_Wr_Ptr;
   logic [AW-1:0]         r_Rd_Ptr;
   logic [CW-1:0]         r_Count;
   logic                  w_Push;
   logic                  w_Pop;

   // Status flags and handshake qualifiers.
   always_comb begin
      o_Full  = (r_Count == CW'(DEPTH));
      o_Empty = (r_Count == '0);
      o_Data  = r_Mem[r_Rd_Ptr];
      w_Push  = i_Data_Valid & ~o_Full;
      w_Pop   = i_Read & ~o_Empty;
   end

   // Storage array, written on accepted pushes only.
   always_ff @(posedge i_Clk) begin
      if (w_Push) begin
         r_Mem[r_Wr_Ptr] <= i_Data;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_Wr_Ptr <= '0;
         r_Rd_Ptr <= '0;
         r_Count  <= '0;
      end else begin
         if (w_Push) begin
            r_Wr_Ptr <= (r_Wr_Ptr == AW'(DEPTH - 1)) ? '0 : r_Wr_Ptr + AW'(1);
         end
         if (w_Pop) begin
            r_Rd_Ptr <= (r_Rd_Ptr == AW'(DEPTH - 1)) ? '0 : r_Rd_Ptr + AW'(1);
         end
         case ({w_Push, w_Pop})
            2'b10:   r_Count <= r_Count + CW'(1);
            2'b01:   r_Count <= r_Count - CW'(1);
            default: r_Count <= r_Count;
         endcase
      end
   end

endmodule

// File: rtl/rr_priority_pick.sv
// Round-robin priority search: first set request at or above i_Start,
// wrapping modulo NUM_REQ (not a power-of-two mask).
module rr_priority_pick #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   i_Req,
   input  logic [IDX_WIDTH-1:0] i_Start,
   output logic                 o_Found,
   output logic [IDX_WIDTH-1:0] o_Idx
);

   // One extra bit so start + offset never overflows before the wrap.
   localparam int unsigned PW = IDX_WIDTH + 1;

   logic [PW-1:0] w_Pos;

   // Scan NUM_REQ positions starting at i_Start; first hit wins.
   always_comb begin
      o_Found = 1'b0;
      o_Idx   = '0;
      w_Pos   = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         w_Pos = {1'b0, i_Start} + PW'(i);
         if (w_Pos >= PW'(NUM_REQ)) begin
            w_Pos = w_Pos - PW'(NUM_REQ);
         end
         if (!o_Found && i_Req[w_Pos[IDX_WIDTH-1:0]]) begin
            o_Found = 1'b1;
            o_Idx   = w_Pos[IDX_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter in front of a single FIFO write port.
// The granted source drives the FIFO write side combinationally.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 17,
   parameter int unsigned IDX_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                          i_Clk,
   input  logic                          i_Rst,
   input  logic [NUM_REQ-1:0]            i_Req,
   input  logic [NUM_REQ-1:0]            i_Last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_Req_Data,
   output logic [NUM_REQ-1:0]            o_Ack,
   output logic [NUM_REQ-1:0]            o_Grant,
   output logic                          o_Busy,
   input  logic                          i_Fifo_Full,
   output logic                          o_Fifo_Data_Valid,
   output logic [DATA_WIDTH-1:0]         o_Fifo_Data
`ifdef SIMULATION
   ,
   output logic                          o_Diag_State,
   output logic [IDX_WIDTH-1:0]          o_Diag_Ptr
`endif
);

   arb_state_t            r_State;
   logic [IDX_WIDTH-1:0]  r_Grant_Idx;
   logic [IDX_WIDTH-1:0]  r_Ptr;
   logic [NUM_REQ-1:0]    r_Grant;
   logic                  r_Busy;

   logic                  w_Found;
   logic [IDX_WIDTH-1:0]  w_Pick_Idx;
   logic                  w_Write;
   logic                  w_Release;
   logic [IDX_WIDTH-1:0]  w_Ptr_Next;
   logic [DATA_WIDTH-1:0] w_Words [NUM_REQ];

   rr_priority_pick #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .i_Req   (i_Req),
      .i_Start (r_Ptr),
      .o_Found (w_Found),
      .o_Idx   (w_Pick_Idx)
   );

   // Write-side drive from the granted source; data mux stays live while stalled.
   always_comb begin
      for (int n = 0; n < int'(NUM_REQ); n++) begin
         w_Words[n] = i_Req_Data[n*DATA_WIDTH +: DATA_WIDTH];
      end
      w_Write           = (r_State == GRANT) & i_Req[r_Grant_Idx] & ~i_Fifo_Full;
      w_Release         = w_Write & i_Last[r_Grant_Idx];
      w_Ptr_Next        = (r_Grant_Idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                                   : r_Grant_Idx + IDX_WIDTH'(1);
      o_Fifo_Data_Valid = w_Write;
      o_Ack             = w_Write ? (NUM_REQ'(1) << r_Grant_Idx) : '0;
      o_Fifo_Data       = (r_State == GRANT) ? w_Words[r_Grant_Idx] : '0;
   end

   // Arbitration FSM: pick at packet boundaries, hold grant until the last word lands.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_State     <= IDLE;
         r_Grant_Idx <= '0;
         r_Ptr       <= '0;
         r_Grant     <= '0;
         r_Busy      <= 1'b0;
      end else begin
         case (r_State)
            IDLE: begin
               if (w_Found) begin
                  r_State     <= GRANT;
                  r_Grant_Idx <= w_Pick_Idx;
                  r_Grant     <= NUM_REQ'(1) << w_Pick_Idx;
                  r_Busy      <= 1'b1;
               end
            end
            GRANT: begin
               if (w_Release) begin
                  r_State <= IDLE;
                  r_Ptr   <= w_Ptr_Next;
                  r_Grant <= '0;
                  r_Busy  <= 1'b0;
               end
            end
            default: r_State <= IDLE;
         endcase
      end
   end

   assign o_Grant = r_Grant;
   assign o_Busy  = r_Busy;

`ifdef SIMULATION
   assign o_Diag_State = r_State;
   assign o_Diag_Ptr   = r_Ptr;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: arbiter driving a real DEPTH=4 FIFO, NUM_REQ=4, DATA_WIDTH=17.
module tb_fifo_wr_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 17;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [3:0]  last;
      logic [16:0] d0, d1, d2, d3;
      logic        rd;
      logic        chk;
      logic [3:0]  e_grant;
      logic        e_busy;
      logic [3:0]  e_ack;
      logic        e_vld;
      logic [16:0] e_fdata;
      logic        e_empty;
      logic [16:0] e_q;
   } vec_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NR-1:0]          req;
   logic [NR-1:0]          last;
   logic [NR-1:0][DW-1:0]  d;
   logic                   rd;
   logic [NR-1:0]          ack;
   logic [NR-1:0]          grant;
   logic                   busy;
   logic                   full;
   logic                   fvld;
   logic [DW-1:0]          fdata;
   logic [DW-1:0]          q;
   logic                   empty;
`ifdef SIMULATION
   logic                   diag_state;
   logic [1:0]             diag_ptr;
`endif

   int n_vec = 0;
   int n_err = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
      .i_Clk             (clk),
      .i_Rst             (rst),
      .i_Req             (req),
      .i_Last            (last),
      .i_Req_Data        (d),
      .o_Ack             (ack),
      .o_Grant           (grant),
      .o_Busy            (busy),
      .i_Fifo_Full       (full),
      .o_Fifo_Data_Valid (fvld),
      .o_Fifo_Data       (fdata)
`ifdef SIMULATION
      ,
      .o_Diag_State      (diag_state),
      .o_Diag_Ptr        (diag_ptr)
`endif
   );

   fifo #(.DATA_WIDTH(DW), .DEPTH(4)) u_fifo (
      .i_Clk        (clk),
      .i_Rst        (rst),
      .i_Data_Valid (fvld),
      .i_Data       (fdata),
      .o_Full       (full),
      .i_Read       (rd),
      .o_Data       (q),
      .o_Empty      (empty)
   );

   function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                               input logic [16:0] a0, input logic [16:0] a1,
                               input logic [16:0] a2, input logic [16:0] a3,
                               input logic rdv, input logic c,
                               input logic [3:0] eg, input logic eb, input logic [3:0] ea,
                               input logic ev, input logic [16:0] ed,
                               input logic ee, input logic [16:0] eq);
      vec_t v;
      v.rst = r; v.req = rq; v.last = ls;
      v.d0 = a0; v.d1 = a1; v.d2 = a2; v.d3 = a3;
      v.rd = rdv; v.chk = c;
      v.e_grant = eg; v.e_busy = eb; v.e_ack = ea; v.e_vld = ev; v.e_fdata = ed;
      v.e_empty = ee; v.e_q = eq;
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [16:0] act, input logic [16:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] eg, input logic eb,
                            input logic [3:0] ea, input logic ev, input logic [16:0] ed);
      n_vec++;
      cmp({tag, " grant"}, 17'(grant), 17'(eg));
      cmp({tag, " busy"},  17'(busy),  17'(eb));
      cmp({tag, " ack"},   17'(ack),   17'(ea));
      cmp({tag, " valid"}, 17'(fvld),  17'(ev));
      cmp({tag, " data"},  fdata,      ed);
   endtask

   task automatic check_q(input string tag, input logic [16:0] eq);
      n_vec++;
      cmp({tag, " empty"}, 17'(empty), 17'(0));
      cmp({tag, " qdata"}, q, eq);
   endtask

   task automatic check_empty(input string tag);
      n_vec++;
      cmp({tag, " empty"}, 17'(empty), 17'(1));
   endtask

   task automatic check_full(input string tag, input logic ef);
      n_vec++;
      cmp({tag, " full"}, 17'(full), 17'(ef));
   endtask

   function automatic logic [16:0] wst(input int k);
      return 17'(32'h01000 + k);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req = '0; last = '0; d = '0; rd = 1'b0;

      // Reset, then single-word packets from all sources.
      tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0,  4'h0, 0, 4'h0, 0, 0,        1, 0));
      tbl.push_back(mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1,  4'h0, 0, 4'h0, 0, 0,        1, 0));
      tbl.push_back(mk(0, 4'hF, 4'hF, 17'h10, 17'h20, 17'h30, 17'h40, 1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 4'hF, 4'hF, 17'h10, 17'h20, 17'h30, 17'h40, 1, 1, 4'h1, 1, 4'h1, 1, 17'h10, 1, 0));
      tbl.push_back(mk(0, 4'hE, 4'hF, 17'h10, 17'h20, 17'h30, 17'h40, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0, 17'h10));
      tbl.push_back(mk(0, 4'hE, 4'hF, 17'h10, 17'h20, 17'h30, 17'h40, 1, 1, 4'h2, 1, 4'h2, 1, 17'h20, 1, 0));
      tbl.push_back(mk(0, 4'hC, 4'hF, 17'h10, 17'h20, 17'h30, 17'h40, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0, 17'h20));
      tbl.push_back(mk(0, 4'hC, 4'hF, 17'h10, 17'h20, 17'h30, 17'h40, 1, 1, 4'h4, 1, 4'h4, 1, 17'h30, 1, 0));
      tbl.push_back(mk(0, 4'h8, 4'hF, 17'h10, 17'h20, 17'h30, 17'h40, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0, 17'h30));
      tbl.push_back(mk(0, 4'h8, 4'hF, 17'h10, 17'h20, 17'h30, 17'h40, 1, 1, 4'h8, 1, 4'h8, 1, 17'h40, 1, 0));
      tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1,  4'h0, 0, 4'h0, 0, 0,        0, 17'h40));
      tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1,  4'h0, 0, 4'h0, 0, 0,        1, 0));
      // Packet contiguity: req0 A1..A3 while req2 waits with B1.
      tbl.push_back(mk(0, 4'h5, 4'h4, 17'h0A001, 0, 17'h0B001, 0, 1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 4'h5, 4'h4, 17'h0A001, 0, 17'h0B001, 0, 1, 1, 4'h1, 1, 4'h1, 1, 17'h0A001, 1, 0));
      tbl.push_back(mk(0, 4'h5, 4'h4, 17'h0A002, 0, 17'h0B001, 0, 1, 1, 4'h1, 1, 4'h1, 1, 17'h0A002, 0, 17'h0A001));
      tbl.push_back(mk(0, 4'h5, 4'h5, 17'h0A003, 0, 17'h0B001, 0, 1, 1, 4'h1, 1, 4'h1, 1, 17'h0A003, 0, 17'h0A002));
      tbl.push_back(mk(0, 4'h4, 4'h4, 0, 0, 17'h0B001, 0, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0, 17'h0A003));
      tbl.push_back(mk(0, 4'h4, 4'h4, 0, 0, 17'h0B001, 0, 1, 1, 4'h4, 1, 4'h4, 1, 17'h0B001, 1, 0));
      tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1, 4'h0, 0, 4'h0, 0, 0, 0, 17'h0B001));
      tbl.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1, 4'h0, 0, 4'h0, 0, 0, 1, 0));

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; req = tbl[i].req; last = tbl[i].last; rd = tbl[i].rd;
         d[0] = tbl[i].d0; d[1] = tbl[i].d1; d[2] = tbl[i].d2; d[3] = tbl[i].d3;
         #1;
         if (tbl[i].chk) begin
            check_all($sformatf("vec%0d", i), tbl[i].e_grant, tbl[i].e_busy,
                      tbl[i].e_ack, tbl[i].e_vld, tbl[i].e_fdata);
            if (tbl[i].e_empty) check_empty($sformatf("vec%0d", i));
            else                check_q($sformatf("vec%0d", i), tbl[i].e_q);
         end
      end

      // Full stall: req1 sends 6 words into a DEPTH=4 FIFO with reads off.
      @(negedge clk);
      rd = 1'b0; d = '0; req = 4'b0010; last = 4'b0000; d[1] = wst(0);
      #1; check_all("stall_arb", 4'h0, 0, 4'h0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); d[1] = wst(k);
         #1; check_all($sformatf("stall_w%0d", k), 4'h2, 1, 4'h2, 1, wst(k));
      end
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); d[1] = wst(4);
         #1; check_full($sformatf("stall_hold%0d", j), 1);
         check_all($sformatf("stall_hold%0d", j), 4'h2, 1, 4'h0, 0, wst(4));
      end
      @(negedge clk); rd = 1'b1;
      #1; check_full("stall_pulse", 1); check_all("stall_pulse", 4'h2, 1, 4'h0, 0, wst(4));
      check_q("stall_pulse", wst(0));
      @(negedge clk); rd = 1'b0;
      #1; check_full("stall_w4", 0); check_all("stall_w4", 4'h2, 1, 4'h2, 1, wst(4));
      @(negedge clk); d[1] = wst(5); last = 4'b0010;
      #1; check_full("stall_refull", 1); check_all("stall_refull", 4'h2, 1, 4'h0, 0, wst(5));
      @(negedge clk); rd = 1'b1;
      #1; check_all("stall_pop1", 4'h2, 1, 4'h0, 0, wst(5)); check_q("stall_pop1", wst(1));
      @(negedge clk);
      #1; check_all("stall_w5", 4'h2, 1, 4'h2, 1, wst(5)); check_q("stall_w5", wst(2));
      @(negedge clk); req = '0; last = '0;
      #1; check_all("stall_done", 4'h0, 0, 4'h0, 0, 0); check_q("stall_drain3", wst(3));
      @(negedge clk); #1; check_q("stall_drain4", wst(4));
      @(negedge clk); #1; check_q("stall_drain5", wst(5));
      @(negedge clk); #1; check_empty("stall_drained");

      // Fairness: req3 and req0 both stream single-word packets.
      for (int p = 0; p < 4; p++) begin
         logic [3:0]  eg;
         logic [16:0] ed;
         eg = (p % 2 == 0) ? 4'b1000 : 4'b0001;
         ed = (p % 2 == 0) ? 17'h00D00 : 17'h00A00;
         @(negedge clk);
         rd = 1'b1; req = 4'b1001; last = 4'b1001; d = '0; d[0] = 17'h00A00; d[3] = 17'h00D00;
         #1; check_all($sformatf("fair_arb%0d", p), 4'h0, 0, 4'h0, 0, 0);
         if (p > 0) check_q($sformatf("fair_q%0d", p), (p % 2 == 1) ? 17'h00D00 : 17'h00A00);
         @(negedge clk);
         #1; check_all($sformatf("fair_gnt%0d", p), eg, 1, eg, 1, ed);
      end
      @(negedge clk); req = '0; last = '0;
      #1; check_q("fair_q4", 17'h00A00);
      @(negedge clk); #1; check_empty("fair_drained");

      // Reset during word 2 of a 4-word packet from req0.
      @(negedge clk);
      req = 4'b0001; last = 4'b0000; d = '0; d[0] = 17'h0C000;
      #1; check_all("rst_arb", 4'h0, 0, 4'h0, 0, 0);
      @(negedge clk);
      #1; check_all("rst_w0", 4'h1, 1, 4'h1, 1, 17'h0C000);
      @(negedge clk); d[0] = 17'h0C001; rst = 1'b1;
      #1; check_all("rst_w1", 4'h1, 1, 4'h1, 1, 17'h0C001);
      @(negedge clk);
      rst = 1'b0; req = 4'b1000; last = 4'b1000; d = '0; d[3] = 17'h00333;
      #1; check_all("rst_after", 4'h0, 0, 4'h0, 0, 0); check_empty("rst_after");
`ifdef SIMULATION
      n_vec++;
      cmp("rst_after ptr", 17'(diag_ptr), 17'(0));
      cmp("rst_after state", 17'(diag_state), 17'(0));
`endif
      @(negedge clk);
      #1; check_all("rst_req3", 4'h8, 1, 4'h8, 1, 17'h00333);
      @(negedge clk); req = '0; last = '0;
      #1; check_all("rst_rel", 4'h0, 0, 4'h0, 0, 0); check_q("rst_q", 17'h00333);
      @(negedge clk); #1; check_empty("rst_drained");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
